// File: rtl/sword_lockout_if.sv
// Bundle of the sword_lockout control, switch and result signals.
// Optional hit counter bus is present only when SWORD_HIT_COUNT_EN is defined.
// master: the side that arms/clears and reads results (scoring logic).
// slave:  the lockout block itself.
interface sword_lockout_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                  arm;
    logic                  clear;
    logic [N_CH-1:0]       sw;
    logic [N_CH-1:0]       v;
    logic [IDX_W-1:0]      winner_idx;
    logic                  valid;
    logic                  tie;
    logic                  armed;
`ifdef SWORD_HIT_COUNT_EN
    logic [N_CH*CNT_W-1:0] hit_cnt;
`endif

    modport master (
        output arm, clear, sw,
        input  v, winner_idx, valid, tie, armed
`ifdef SWORD_HIT_COUNT_EN
        , input hit_cnt
`endif
    );

    modport slave (
        input  arm, clear, sw,
        output v, winner_idx, valid, tie, armed
`ifdef SWORD_HIT_COUNT_EN
        , output hit_cnt
`endif
    );
endinterface

// File: rtl/sword_lockout.sv
// sword_lockout: first-hit lockout across N_CH debounced switch channels.
// Once armed, the lowest-index channel asserting in the capture cycle wins;
// the result is held until clear/reset, or for HOLD_CYCLES cycles followed
// by an automatic re-arm once all switches are released.
// Optional feature macro: SWORD_HIT_COUNT_EN (per-channel saturating hit
// counters on the hit_cnt bus). Default build leaves it out.
module sword_lockout #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 0,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    sword_lockout_if.slave    bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        ARMED    = 2'd2,
        LOCKED   = 2'd3
    } state_e;

    state_e           state_q;
    logic [N_CH-1:0]  v_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             tie_q;
    logic             armed_q;
    logic [HC_W-1:0]  hold_q;

    logic             sw_any;
    logic             capture;
    logic [IDX_W-1:0] cap_idx;

    // Lowest-index set bit wins; scanning downward leaves the smallest index.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CH-1:0] s);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (s[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign sw_any  = |bus.sw;
    assign cap_idx = lowest_set(bus.sw);
    // A capture happens only from ARMED, and clear outranks a switch hit.
    assign capture = (state_q == ARMED) && !bus.clear && sw_any;

    // Lockout FSM with registered result outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset || bus.clear) begin
            state_q <= IDLE;
            v_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tie_q   <= 1'b0;
            armed_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        // A switch already closed at arm time must be released first.
                        if (sw_any) begin
                            state_q <= WAIT_REL;
                        end else begin
                            state_q <= ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                end
                WAIT_REL: begin
                    if (!sw_any) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (sw_any) begin
                        state_q <= LOCKED;
                        armed_q <= 1'b0;
                        // Isolate the lowest set bit: sw & -sw.
                        v_q     <= bus.sw & (~bus.sw + N_CH'(1));
                        idx_q   <= cap_idx;
                        valid_q <= 1'b1;
                        tie_q   <= (bus.sw & (bus.sw - N_CH'(1))) != '0;
                        hold_q  <= '0;
                    end
                end
                LOCKED: begin
                    // With HOLD_CYCLES == 0 the result is frozen until clear/reset.
                    if (HOLD_CYCLES != 0) begin
                        if (hold_q == HOLD_LAST) begin
                            state_q <= WAIT_REL;
                            v_q     <= '0;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            tie_q   <= 1'b0;
                            hold_q  <= '0;
                        end else begin
                            hold_q  <= hold_q + HC_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.v          = v_q;
    assign bus.winner_idx = idx_q;
    assign bus.valid      = valid_q;
    assign bus.tie        = tie_q;
    assign bus.armed      = armed_q;

`ifdef SWORD_HIT_COUNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Next-state of the hit counters: bump the winner, saturating at all-ones.
    always_comb begin
        // NOTE: the whole array gets a default first so no path leaves a
        // counter unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (capture && (cnt_q[cap_idx] != '1)) begin
            cnt_d[cap_idx] = cnt_q[cap_idx] + CNT_W'(1);
        end
    end

    // Hit counters survive clear and auto-release; only reset zeroes them.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is reset explicitly because its
        // contents are architecturally visible, unlike a RAM left uninitialised.
        if (reset) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_hit_out
        assign bus.hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    // Without hit counters the capture strobe has no consumer.
    logic unused_capture;
    assign unused_capture = capture;
`endif
endmodule

// File: tb/tb_sword_lockout.sv
// Scoreboard bench for sword_lockout: two instances (hold-until-clear and
// HOLD_CYCLES=3). Stimulus pushes the expected post-edge outputs into a
// per-instance queue; a monitor per instance pops and compares after each edge.
module tb_sword_lockout;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    sword_lockout_if #(.N_CH(4), .CNT_W(2)) bus_a ();
    sword_lockout_if #(.N_CH(4), .CNT_W(2)) bus_b ();

    sword_lockout #(.N_CH(4), .HOLD_CYCLES(0), .CNT_W(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    sword_lockout #(.N_CH(4), .HOLD_CYCLES(3), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        logic [3:0] v;
        logic [1:0] idx;
        logic       valid;
        logic       tie;
        logic       armed;
        logic [1:0] hit0;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic exp_t mk(input logic [3:0] v, input logic [1:0] idx,
                                input logic valid, input logic tie,
                                input logic armed, input logic [1:0] hit0);
        exp_t e;
        e.v = v; e.idx = idx; e.valid = valid; e.tie = tie; e.armed = armed; e.hit0 = hit0;
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for instance A.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a.v",     8'(bus_a.v),          8'(e.v));
            check("a.idx",   8'(bus_a.winner_idx), 8'(e.idx));
            check("a.valid", 8'(bus_a.valid),      8'(e.valid));
            check("a.tie",   8'(bus_a.tie),        8'(e.tie));
            check("a.armed", 8'(bus_a.armed),      8'(e.armed));
`ifdef SWORD_HIT_COUNT_EN
            check("a.hit0",  8'(bus_a.hit_cnt[1:0]), 8'(e.hit0));
`endif
        end
    end

    // Monitor for instance B.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b.v",     8'(bus_b.v),          8'(e.v));
            check("b.idx",   8'(bus_b.winner_idx), 8'(e.idx));
            check("b.valid", 8'(bus_b.valid),      8'(e.valid));
            check("b.tie",   8'(bus_b.tie),        8'(e.tie));
            check("b.armed", 8'(bus_b.armed),      8'(e.armed));
`ifdef SWORD_HIT_COUNT_EN
            check("b.hit0",  8'(bus_b.hit_cnt[1:0]), 8'(e.hit0));
`endif
        end
    end

    task automatic step_a(input logic rst, input logic clr, input logic arm,
                          input logic [3:0] sw, input exp_t e);
        @(negedge clk);
        rst_a       = rst;
        bus_a.clear = clr;
        bus_a.arm   = arm;
        bus_a.sw    = sw;
        q_a.push_back(e);
    endtask

    task automatic step_b(input logic rst, input logic clr, input logic arm,
                          input logic [3:0] sw, input exp_t e);
        @(negedge clk);
        rst_b       = rst;
        bus_b.clear = clr;
        bus_b.arm   = arm;
        bus_b.sw    = sw;
        q_b.push_back(e);
    endtask

    initial begin
        logic [1:0] hit_tab [4];
        logic [1:0] prev;
        hit_tab = '{2'd1, 2'd2, 2'd3, 2'd3};

        bus_a.arm = 1'b0; bus_a.clear = 1'b0; bus_a.sw = '0;
        bus_b.arm = 1'b0; bus_b.clear = 1'b0; bus_b.sw = '0;

        // ---- Instance A: hold until clear ----
        // Reset, arm, single capture on channel 2, hold, late hit ignored.
        step_a(1, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        step_a(0, 0, 1, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 0));
        step_a(0, 0, 0, 4'b0100, mk(4'b0100, 2, 1, 0, 0, 0));
        step_a(0, 0, 0, 4'b0000, mk(4'b0100, 2, 1, 0, 0, 0));
        step_a(0, 0, 0, 4'b0001, mk(4'b0100, 2, 1, 0, 0, 0));
        step_a(0, 1, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        // Simultaneous hit 1010: lowest index wins, tie flagged.
        step_a(0, 0, 1, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 0));
        step_a(0, 0, 0, 4'b1010, mk(4'b0010, 1, 1, 1, 0, 0));
        step_a(0, 1, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        // Arm with switch held: WAIT_REL, no capture, re-arm after release.
        step_a(0, 0, 1, 4'b0001, mk(4'b0000, 0, 0, 0, 0, 0));
        step_a(0, 0, 1, 4'b0001, mk(4'b0000, 0, 0, 0, 0, 0));
        step_a(0, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 0));
        step_a(0, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 0));
        // Capture then reset+clear+arm together: reset wins.
        step_a(0, 0, 0, 4'b1000, mk(4'b1000, 3, 1, 0, 0, 0));
        step_a(1, 1, 1, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        // Capture then clear+arm together: clear wins, stays IDLE.
        step_a(0, 0, 1, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 0));
        step_a(0, 0, 0, 4'b0001, mk(4'b0001, 0, 1, 0, 0, 1));
        step_a(0, 1, 1, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 1));
        step_a(0, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 1));
        // Four channel-0 captures from a fresh reset: counter 1,2,3,3.
        step_a(1, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            prev = (k == 0) ? 2'd0 : hit_tab[k-1];
            step_a(0, 0, 1, 4'b0000, mk(4'b0000, 0, 0, 0, 1, prev));
            step_a(0, 0, 0, 4'b0001, mk(4'b0001, 0, 1, 0, 0, hit_tab[k]));
            step_a(0, 1, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, hit_tab[k]));
        end
        step_a(1, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));

        // ---- Instance B: HOLD_CYCLES = 3 ----
        step_b(1, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 0));
        step_b(0, 0, 1, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 0));
        step_b(0, 0, 0, 4'b1000, mk(4'b1000, 3, 1, 0, 0, 0));
        step_b(0, 0, 0, 4'b1000, mk(4'b1000, 3, 1, 0, 0, 0));
        step_b(0, 0, 1, 4'b1000, mk(4'b1000, 3, 1, 0, 0, 0));
        // Auto-release after exactly three valid cycles; switch still held.
        step_b(0, 0, 0, 4'b1000, mk(4'b0000, 0, 0, 0, 0, 0));
        step_b(0, 0, 0, 4'b1000, mk(4'b0000, 0, 0, 0, 0, 0));
        step_b(0, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 0));
        // Second hit on channel 0 after automatic re-arm.
        step_b(0, 0, 0, 4'b0001, mk(4'b0001, 0, 1, 0, 0, 1));
        step_b(0, 0, 0, 4'b0001, mk(4'b0001, 0, 1, 0, 0, 1));
        step_b(0, 0, 0, 4'b0001, mk(4'b0001, 0, 1, 0, 0, 1));
        step_b(0, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 1));
        step_b(0, 0, 0, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 1));
        step_b(0, 0, 0, 4'b0110, mk(4'b0010, 1, 1, 1, 0, 1));

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", q_a.size() + q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
